// File: rtl/ifu_fetch_queue_pkg.sv
// Shared fetch definitions: machine widths, NOP encoding, RVC detect and fetch-entry layout.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ifu_fetch_queue_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned INST_LEN = 32;

   // addi x0, x0, 0: substituted for the instruction word of a faulting fetch
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   // Fetch-entry packing, LSB first: {pc, inst, rvc, fault}
   localparam int unsigned FE_FAULT_OFF = 0;
   localparam int unsigned FE_RVC_OFF   = 1;
   localparam int unsigned FE_INST_OFF  = 2;

   function automatic int unsigned fe_width(input int unsigned pc_w, input int unsigned inst_w);
      return pc_w + inst_w + 2;
   endfunction

   // Compressed instructions are the ones whose two low bits are not 2'b11
   function automatic logic is_rvc(input logic [1:0] low_bits);
      return low_bits != 2'b11;
   endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Generic synchronous FIFO, registered storage, index plus wrap-bit pointers, sync clear.
// Latency: a pushed word appears at head_dat_o the cycle after the push.
// Backpressure: none internal; a push into a full FIFO lands only if a pop happens the same cycle.
module ifu_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   localparam int unsigned   IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic             wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
   logic             do_push, do_pop;

   assign empty_o    = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
   assign full_o     = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
   assign do_pop     = pop_i & ~empty_o;
   assign do_push    = push_i & (~full_o | do_pop);
   assign head_dat_o = mem_q[rd_idx_q];

   // Occupancy from pointer distance; the wrap bits tell full apart from empty
   always_comb begin
      if (wr_wrap_q == rd_wrap_q) begin
         count_o = CW'(wr_idx_q) - CW'(rd_idx_q);
      end else begin
         count_o = CW'(DEPTH) - CW'(rd_idx_q) + CW'(wr_idx_q);
      end
   end

   // Pointer advance: the index wraps at DEPTH-1 and toggles the wrap bit, so any depth works
   always_comb begin
      wr_idx_d  = wr_idx_q;
      wr_wrap_d = wr_wrap_q;
      rd_idx_d  = rd_idx_q;
      rd_wrap_d = rd_wrap_q;
      if (do_push) begin
         if (wr_idx_q == LAST) begin
            wr_idx_d  = '0;
            wr_wrap_d = ~wr_wrap_q;
         end else begin
            wr_idx_d = wr_idx_q + IW'(1);
         end
      end
      if (do_pop) begin
         if (rd_idx_q == LAST) begin
            rd_idx_d  = '0;
            rd_wrap_d = ~rd_wrap_q;
         end else begin
            rd_idx_d = rd_idx_q + IW'(1);
         end
      end
   end

   // Pointer registers; reset and clear both empty the FIFO
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         wr_idx_q  <= '0;
         wr_wrap_q <= 1'b0;
         rd_idx_q  <= '0;
         rd_wrap_q <= 1'b0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_wrap_q <= wr_wrap_d;
         rd_idx_q  <= rd_idx_d;
         rd_wrap_q <= rd_wrap_d;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push && !clr_i && !rst) begin
         mem_q[wr_idx_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch stage: issues in-order icache requests, pairs responses with their PC, queues them for decode.
// Latency: icache response to id_valid_o is 1 cycle (registered queue, no bypass).
// Backpressure: credit-based request issue; pc_stall_o holds the PC register unless a request fires.
module ifu_fetch_queue
   import ifu_fetch_queue_pkg::*;
#(
   parameter int unsigned PC_W       = XLEN,
   parameter int unsigned INST_W     = INST_LEN,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_OUT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              pc_req_valid_i,
   input  logic [PC_W-1:0]   pc_req_addr_i,
   output logic              pc_stall_o,
   output logic              icache_req_valid_o,
   output logic [PC_W-1:0]   icache_req_addr_o,
   input  logic              icache_req_ready_i,
   input  logic              icache_resp_valid_i,
   input  logic [INST_W-1:0] icache_resp_data_i,
   input  logic              icache_resp_err_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [PC_W-1:0]   id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_rvc_o,
   output logic              id_fault_o
);

   localparam int unsigned FE_W      = fe_width(PC_W, INST_W);
   localparam int unsigned FE_PC_OFF = FE_INST_OFF + INST_W;
   localparam int unsigned CNT_W     = $clog2(MAX_OUT + 1);
   localparam int unsigned IF_W      = CNT_W + 1;
   localparam int unsigned QC_W      = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W     = QC_W + 1;
   localparam int unsigned TC_W      = $clog2(MAX_OUT + 1);

   logic [CNT_W-1:0]  live_cnt_q, live_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [IF_W-1:0]   inflight;
   logic [QC_W-1:0]   q_count;
   logic [TC_W-1:0]   tag_count;
   logic              q_empty, q_full, tag_empty, tag_full;
   logic              credit, fire, resp_ok, drop_resp, keep_resp;
   logic [PC_W-1:0]   tag_pc;
   logic [INST_W-1:0] resp_inst;
   logic              resp_rvc;
   logic [FE_W-1:0]   resp_entry, head_entry;
   logic              unused_status;

   assign inflight = IF_W'(live_cnt_q) + IF_W'(drop_cnt_q);

   // Kept responses still in flight must already own a queue slot, hence live_cnt + occupancy
   assign credit = (inflight < IF_W'(MAX_OUT)) &&
                   ((SUM_W'(live_cnt_q) + SUM_W'(q_count)) < SUM_W'(FIFO_DEPTH));

   assign icache_req_valid_o = pc_req_valid_i & credit & ~flush_i & ~rst;
   assign icache_req_addr_o  = pc_req_addr_i;
   assign fire               = icache_req_valid_o & icache_req_ready_i;
   assign pc_stall_o         = rst | (~fire & ~flush_i);

   // Responses with nothing in flight are stray and ignored; older stale ones drain first
   assign resp_ok   = icache_resp_valid_i & (inflight != '0);
   assign drop_resp = resp_ok & (drop_cnt_q != '0);
   assign keep_resp = resp_ok & (drop_cnt_q == '0) & ~flush_i;

   assign resp_inst  = icache_resp_err_i ? INST_W'(INST_NOP) : icache_resp_data_i;
   assign resp_rvc   = ~icache_resp_err_i & is_rvc(icache_resp_data_i[1:0]);
   assign resp_entry = {tag_pc, resp_inst, resp_rvc, icache_resp_err_i};

   // Counter update: a flush turns everything in flight into drops, minus a response landing now
   always_comb begin
      live_cnt_d = live_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (flush_i) begin
         live_cnt_d = '0;
         drop_cnt_d = CNT_W'(inflight - IF_W'(resp_ok));
      end else begin
         if (fire && !keep_resp) begin
            live_cnt_d = live_cnt_q + CNT_W'(1);
         end else if (!fire && keep_resp) begin
            live_cnt_d = live_cnt_q - CNT_W'(1);
         end
         if (drop_resp) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end
      end
   end

   // Outstanding-request counters
   always_ff @(posedge clk) begin
      if (rst) begin
         live_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         live_cnt_q <= live_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // PC of each kept in-flight request, in issue order
   ifu_sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUT)) u_tag_q (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (flush_i),
      .push_i     (fire),
      .push_dat_i (pc_req_addr_i),
      .pop_i      (keep_resp),
      .head_dat_o (tag_pc),
      .empty_o    (tag_empty),
      .full_o     (tag_full),
      .count_o    (tag_count)
   );

   // Completed fetch entries waiting for decode
   ifu_sync_fifo #(.WIDTH(FE_W), .DEPTH(FIFO_DEPTH)) u_inst_q (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (flush_i),
      .push_i     (keep_resp),
      .push_dat_i (resp_entry),
      .pop_i      (id_valid_o & id_ready_i),
      .head_dat_o (head_entry),
      .empty_o    (q_empty),
      .full_o     (q_full),
      .count_o    (q_count)
   );

   // Occupancy is bounded by credit, so these status flags carry no extra information
   assign unused_status = ^{tag_empty, tag_full, tag_count, q_full};

   // Fields are zeroed when empty so stale storage never reaches decode
   assign id_valid_o = ~q_empty;
   assign id_pc_o    = id_valid_o ? head_entry[FE_PC_OFF +: PC_W] : '0;
   assign id_inst_o  = id_valid_o ? head_entry[FE_INST_OFF +: INST_W] : '0;
   assign id_rvc_o   = id_valid_o & head_entry[FE_RVC_OFF];
   assign id_fault_o = id_valid_o & head_entry[FE_FAULT_OFF];

endmodule
